// File: rtl/wb_pwm_bank_if.sv
// Wishbone slave bus bundle for wb_pwm_bank; signal names follow the user-project
// Wishbone port names so the wrapper can connect them one-to-one.
interface wb_pwm_bank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_pwm_bank.sv
// Wishbone-slave PWM bank: shared period counter, per-channel duty/invert/oe, shadow
// registers loaded at period wrap. Define PWM_IRQ_EN to enable the wrap-flag interrupt.
module wb_pwm_bank #(
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_pwm_bank_if.slave        wbs,
    output logic [CHANNELS-1:0] pwm_o,
    output logic [CHANNELS-1:0] pwm_oeb,
    output logic                irq_o
);

    logic                ack_q;
    logic [31:0]         dat_q;
    logic                enable_q;
    logic                irq_en_q;
    logic [CHANNELS-1:0] invert_q;
    logic [CHANNELS-1:0] oe_q;
    logic [WIDTH-1:0]    cnt_q;
    logic [WIDTH-1:0]    period_sh_q;
    logic [WIDTH-1:0]    period_act_q;
    logic [WIDTH-1:0]    duty_sh_q  [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [15:0]         wrap_cnt_q;
    logic                irq_flag_q;

    logic                bus_sel;
    logic                bus_req;
    logic                wr_en;
    logic                wrap;
    logic [7:0]          offset;
    logic                hit_ctrl;
    logic                hit_period;
    logic                hit_status;
    logic [CHANNELS-1:0] hit_duty;
    logic [31:0]         ctrl_word;
    logic [31:0]         ctrl_new;
    logic [31:0]         period_new;
    logic [31:0]         duty_new [CHANNELS];
    logic [31:0]         rdata;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign bus_sel   = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                       (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign bus_req   = bus_sel & ~ack_q;
    assign wr_en     = bus_req & wbs.wbs_we_i;
    assign offset    = wbs.wbs_adr_i[7:0];
    assign wrap      = enable_q & (cnt_q == period_act_q);
    assign ctrl_word = {8'h00, 8'(oe_q), 8'(invert_q), 6'b0, irq_en_q, enable_q};

    always_comb begin
        hit_ctrl   = (offset == 8'h00);
        hit_period = (offset == 8'h04);
        hit_status = (offset == 8'h08);
        ctrl_new   = lane_merge(ctrl_word, wbs.wbs_dat_i, wbs.wbs_sel_i);
        period_new = lane_merge(32'(period_sh_q), wbs.wbs_dat_i, wbs.wbs_sel_i);
        rdata      = '0;
        if (hit_ctrl)   rdata = ctrl_word;
        if (hit_period) rdata = 32'(period_sh_q);
        if (hit_status) rdata = {wrap_cnt_q, 15'b0, irq_flag_q};
        for (int i = 0; i < CHANNELS; i++) begin
            hit_duty[i] = (offset == 8'(16 + 4 * i));
            duty_new[i] = lane_merge(32'(duty_sh_q[i]), wbs.wbs_dat_i, wbs.wbs_sel_i);
            if (hit_duty[i]) rdata = 32'(duty_sh_q[i]);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            invert_q     <= '0;
            oe_q         <= '0;
            cnt_q        <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            wrap_cnt_q   <= '0;
            pwm_o        <= '0;
            pwm_oeb      <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            ack_q <= bus_req;
            dat_q <= bus_req ? rdata : '0;

            if (wr_en && hit_ctrl) begin
                enable_q <= ctrl_new[0];
                irq_en_q <= ctrl_new[1];
                invert_q <= ctrl_new[8 +: CHANNELS];
                oe_q     <= ctrl_new[16 +: CHANNELS];
            end
            if (wr_en && hit_period) period_sh_q <= period_new[WIDTH-1:0];
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && hit_duty[i]) duty_sh_q[i] <= duty_new[i][WIDTH-1:0];
            end

            // Active registers sample the shadows before this edge's bus write lands.
            if (!enable_q || wrap) begin
                cnt_q        <= '0;
                period_act_q <= period_sh_q;
                for (int i = 0; i < CHANNELS; i++) duty_act_q[i] <= duty_sh_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (wrap) wrap_cnt_q <= wrap_cnt_q + 16'd1;

            for (int i = 0; i < CHANNELS; i++) begin
                pwm_o[i] <= (enable_q & (cnt_q < duty_act_q[i])) ^ invert_q[i];
            end
            pwm_oeb <= ~oe_q;
        end
    end

`ifdef PWM_IRQ_EN
    // A wrap wins over a simultaneous write-1-clear so no wrap event is lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_flag_q <= 1'b0;
        end else if (wrap && irq_en_q) begin
            irq_flag_q <= 1'b1;
        end else if (wr_en && hit_status && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) begin
            irq_flag_q <= 1'b0;
        end
    end
`else
    assign irq_flag_q = 1'b0;
`endif

    assign irq_o         = irq_flag_q;
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

endmodule
